fir_output_capture: RTL and testbench

- Sink-side counterpart of the filter stimulus path: captures the FIR output stream (yn) into an internal buffer so a bench or host can read it back later.
- Discards a programmable number of start-up samples (the filter transient), then stores DEPTH consecutive valid samples.
- Tracks the signed peak of the stored samples, then serves the buffer through a read handshake.
- Sits directly after gaussian_fir in simulation benches and on-chip debug paths.

---
 rtl/fir_output_capture.sv | 129 ++++++++++++
 tb/tb_fir_output_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fir_output_capture.sv
// fir_output_capture: sink for the FIR output stream.
// Discards SKIP start-up samples, stores DEPTH samples while tracking the
// signed peak, then serves the buffer through a latency-1 read handshake.
module fir_output_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SKIP  = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         yn,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         peak
);

    localparam int AW = $clog2(DEPTH);
    // Skip counter runs 0..SKIP-1; keep at least one bit so SKIP=0/1 elaborate.
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SW-1:0]    SKIP_LAST = SW'((SKIP > 0) ? (SKIP - 1) : 0);
    localparam logic [AW-1:0]    PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] PEAK_INIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [AW:0]      COUNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t            state;
    logic [SW-1:0]     skip_cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Two's-complement comparison used by the peak tracker.
    function automatic logic signed_gt(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

    // busy reflects the state directly: high whenever a capture is in flight.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Sample buffer; contents need no reset, writes only while capturing.
    always_ff @(posedge clock) begin
        if (state == S_CAPTURE && in_valid) begin
            mem[wr_ptr] <= yn;
        end
    end

    // Capture FSM with its counters, pointers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            peak     <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Sample on the start cycle itself is deliberately ignored.
                    if (start) begin
                        skip_cnt <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        count    <= '0;
                        peak     <= PEAK_INIT;
                        state    <= (SKIP > 0) ? S_SKIP : S_CAPTURE;
                    end
                end
                S_SKIP: begin
                    if (in_valid) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state <= S_CAPTURE;
                        end else begin
                            skip_cnt <= skip_cnt + {{(SW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
                        count  <= count + COUNT_ONE;
                        if (signed_gt(yn, peak)) begin
                            peak <= yn;
                        end
                        // Stop at DEPTH writes; no wrap-around overwrite.
                        if (wr_ptr == PTR_LAST) begin
                            state <= S_READOUT;
                        end
                    end
                end
                S_READOUT: begin
                    if (rd_en) begin
                        rd_data  <= mem[rd_ptr];
                        rd_valid <= 1'b1;
                        rd_ptr   <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
                        if (rd_ptr == PTR_LAST) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_output_capture.sv
// Scoreboard bench for fir_output_capture (WIDTH=32, DEPTH=4, SKIP=2).
// Stimulus pushes expected read responses; a negedge monitor pops and compares.
module tb_fir_output_capture;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] yn;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [2:0]  count;
    logic [31:0] peak;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;
    int done_expected = 0;

    logic [31:0] exp_data_q [$];
    logic        exp_done_q [$];
    logic [31:0] mon_d;
    logic        mon_dn;

    fir_output_capture #(.WIDTH(32), .DEPTH(4), .SKIP(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .yn       (yn),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .peak     (peak)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic cyc(input logic s, input logic v, input logic [31:0] y, input logic r);
        start = s; in_valid = v; yn = y; rd_en = r;
        @(posedge clock);
        #1;
        start = 1'b0; in_valid = 1'b0; yn = 32'h0; rd_en = 1'b0;
    endtask

    // Start a capture and feed six valid samples (two skipped, four stored).
    // With gap set, an idle cycle carrying stray start/rd_en follows each sample.
    task automatic capture(input logic [31:0] s [6], input bit gap, input logic [31:0] start_sample);
        cyc(1'b1, 1'b1, start_sample, 1'b0);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("count_cleared", 32'(count), 32'd0);
        chk("peak_init", peak, 32'h8000_0000);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, s[i], 1'b0);
            if (gap && i < 5) begin
                cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
            end
        end
    endtask

    // Hold rd_en for four cycles, expecting e0..e3 with done on the last.
    task automatic readout(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            exp_data_q.push_back(e[i]);
            exp_done_q.push_back(i == 3);
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
        end
        done_expected++;
    endtask

    // Monitor: compare every presented read against the scoreboard.
    always @(negedge clock) begin
        if (rd_valid) begin
            if (exp_data_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rd_valid: got rd_data %h with no read pending at %0t", rd_data, $time);
            end else begin
                mon_d  = exp_data_q.pop_front();
                mon_dn = exp_done_q.pop_front();
                chk("rd_data", rd_data, mon_d);
                chk("done_with_read", 32'(done), 32'(mon_dn));
            end
        end else if (done) begin
            chk("done_without_rd_valid", 32'(rd_valid), 32'd1);
        end
        if (done) begin
            done_seen++;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; yn = 32'h0; rd_en = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_peak", peak, 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Basic capture; sample presented with start (999) is not counted.
        capture('{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60}, 1'b0, 32'd999);
        chk("basic_count", 32'(count), 32'd4);
        chk("basic_peak", peak, 32'd60);
        chk("basic_busy_readout", 32'(busy), 32'd1);
        readout(32'd30, 32'd40, 32'd50, 32'd60);
        chk("basic_busy_after_done", 32'(busy), 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("basic_done_count", 32'(done_seen), 32'(done_expected));
        chk("basic_count_hold", 32'(count), 32'd4);
        chk("basic_peak_hold", peak, 32'd60);
        chk("rd_data_hold", rd_data, 32'd60);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);   // rd_en in IDLE: no read

        // Gapped input with stray start/rd_en, then a 5th sample after DEPTH.
        capture('{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60}, 1'b1, 32'd7);
        cyc(1'b0, 1'b1, 32'd70, 1'b0);
        chk("gap_count", 32'(count), 32'd4);
        chk("gap_peak", peak, 32'd60);
        readout(32'd30, 32'd40, 32'd50, 32'd60);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("gap_done_count", 32'(done_seen), 32'(done_expected));

        // Signed peak: large skipped samples must not influence it.
        capture('{32'd100, 32'd200, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFD},
                1'b0, 32'd0);
        chk("signed_peak", peak, 32'hFFFF_FFFF);
        readout(32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("signed_done_count", 32'(done_seen), 32'(done_expected));

        // Reset after two of four captured samples.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'd1, 1'b0);
        cyc(1'b0, 1'b1, 32'd2, 1'b0);
        cyc(1'b0, 1'b1, 32'd3, 1'b0);
        cyc(1'b0, 1'b1, 32'd4, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_peak", peak, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        capture('{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16}, 1'b0, 32'd0);
        chk("post_reset_peak", peak, 32'd16);
        readout(32'd13, 32'd14, 32'd15, 32'd16);

        // Back-to-back: start in the done cycle, square-wave input.
        capture('{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0}, 1'b0, 32'd1);
        chk("b2b_count", 32'(count), 32'd4);
        chk("b2b_peak", peak, 32'd1);
        readout(32'd1, 32'd0, 32'd1, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("final_done_count", 32'(done_seen), 32'(done_expected));
        chk("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
